// File: rtl/fb_id_ex.sv
// Firebird ID/EX pipeline register: captures decoded ops, resolves ALU operands by
// forwarding from EX/MEM and MEM/WB, and inserts one bubble per load-use hazard.
module fb_id_ex #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 19,
  parameter int RAW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [CTRL_W-1:0] id_alu_control,
  input  logic [RAW-1:0]    id_rs1,
  input  logic [RAW-1:0]    id_rs2,
  input  logic [RAW-1:0]    id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_use_pc,
  input  logic              id_use_imm,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic [RAW-1:0]    exmem_rd,
  input  logic              exmem_rd_we,
  input  logic [XLEN-1:0]   exmem_res,
  input  logic [RAW-1:0]    memwb_rd,
  input  logic              memwb_rd_we,
  input  logic [XLEN-1:0]   memwb_data,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_alu_control,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [RAW-1:0]    ex_rd,
  output logic              ex_rd_we,
  output logic              ex_is_load
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [RAW-1:0]    rd;
    logic              rd_we;
    logic              is_load;
    logic              use_pc;
    logic              use_imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [RAW-1:0]    rs1;
    logic [RAW-1:0]    rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic [XLEN-1:0] fwd1, fwd2;
  logic            lu;

  // EX/MEM outranks MEM/WB since it holds the younger write to the same register.
  function automatic logic [XLEN-1:0] fwd(
    input logic [RAW-1:0]  idx,
    input logic [XLEN-1:0] stored,
    input logic [RAW-1:0]  a_rd,
    input logic            a_we,
    input logic [XLEN-1:0] a_val,
    input logic [RAW-1:0]  b_rd,
    input logic            b_we,
    input logic [XLEN-1:0] b_val
  );
    if (idx == '0)                 return '0;
    else if (a_we && a_rd == idx)  return a_val;
    else if (b_we && b_rd == idx)  return b_val;
    else                           return stored;
  endfunction

  assign fwd1 = fwd(ex_q.rs1, ex_q.rs1_data, exmem_rd, exmem_rd_we, exmem_res,
                    memwb_rd, memwb_rd_we, memwb_data);
  assign fwd2 = fwd(ex_q.rs2, ex_q.rs2_data, exmem_rd, exmem_rd_we, exmem_res,
                    memwb_rd, memwb_rd_we, memwb_data);

  assign lu = ex_q.valid && ex_q.is_load && ex_q.rd_we && (ex_q.rd != '0) && id_valid &&
              (((ex_q.rd == id_rs1) && !id_use_pc) || ((ex_q.rd == id_rs2) && !id_use_imm));

  assign id_ready = ex_ready && !lu && !flush;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid = 1'b0;
      ex_d.ctrl  = '0;
    end else if (!ex_ready) begin
      // Latch forwarded values so they survive their producer leaving the pipe.
      ex_d.rs1_data = fwd1;
      ex_d.rs2_data = fwd2;
    end else if (lu) begin
      ex_d.valid = 1'b0;
      ex_d.ctrl  = '0;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.ctrl     = id_alu_control;
      ex_d.rd       = id_rd;
      ex_d.rd_we    = id_rd_we;
      ex_d.is_load  = id_is_load;
      ex_d.use_pc   = id_use_pc;
      ex_d.use_imm  = id_use_imm;
      ex_d.pc       = id_pc;
      ex_d.imm      = id_imm;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      // The regfile write in this same cycle is not yet visible in id_rsN_data.
      ex_d.rs1_data = (memwb_rd_we && memwb_rd == id_rs1 && id_rs1 != '0) ? memwb_data : id_rs1_data;
      ex_d.rs2_data = (memwb_rd_we && memwb_rd == id_rs2 && id_rs2 != '0) ? memwb_data : id_rs2_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid       = ex_q.valid;
  assign ex_alu_control = ex_q.valid ? ex_q.ctrl : '0;
  assign ex_op1         = ex_q.use_pc  ? ex_q.pc  : fwd1;
  assign ex_op2         = ex_q.use_imm ? ex_q.imm : fwd2;
  assign ex_rd          = ex_q.rd;
  assign ex_rd_we       = ex_q.rd_we;
  assign ex_is_load     = ex_q.is_load;

endmodule

// File: tb/tb_fb_id_ex.sv
// Scoreboarded bench for fb_id_ex: inputs change on the falling edge, outputs are
// sampled 1ns later, so each check sees the state captured on the prior rising edge.
module tb_fb_id_ex;
  localparam int XLEN = 32, CTRL_W = 19, RAW = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_ready, id_rd_we, id_is_load, id_use_pc, id_use_imm;
  logic [CTRL_W-1:0] id_alu_control, ex_alu_control;
  logic [RAW-1:0] id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd, ex_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_pc, id_imm, exmem_res, memwb_data, ex_op1, ex_op2;
  logic flush, ex_ready, exmem_rd_we, memwb_rd_we, ex_valid, ex_rd_we, ex_is_load;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  fb_id_ex #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RAW(RAW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_control(id_alu_control), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_pc(id_pc), .id_imm(id_imm), .id_use_pc(id_use_pc),
    .id_use_imm(id_use_imm), .flush(flush), .ex_ready(ex_ready), .exmem_rd(exmem_rd),
    .exmem_rd_we(exmem_rd_we), .exmem_res(exmem_res), .memwb_rd(memwb_rd),
    .memwb_rd_we(memwb_rd_we), .memwb_data(memwb_data), .ex_valid(ex_valid),
    .ex_alu_control(ex_alu_control), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load)
  );

  task automatic idle();
    id_valid = 0; id_alu_control = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rd_we = 0; id_is_load = 0; id_rs1_data = '0; id_rs2_data = '0;
    id_pc = '0; id_imm = '0; id_use_pc = 0; id_use_imm = 0;
    flush = 0; ex_ready = 1;
    exmem_rd = '0; exmem_rd_we = 0; exmem_res = '0;
    memwb_rd = '0; memwb_rd_we = 0; memwb_data = '0;
  endtask

  task automatic drive_id(input logic [CTRL_W-1:0] c, input logic [RAW-1:0] r1, r2, rd,
                          input logic [XLEN-1:0] d1, d2);
    id_valid = 1; id_alu_control = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rd_we = 1; id_rs1_data = d1; id_rs2_data = d2;
  endtask

  task automatic test_reset();
    idle();
    #1;
    checks++; if ({ex_valid, ex_alu_control, ex_rd, ex_rd_we, ex_is_load} !== '0)
      $display("FAIL reset_ctl got v=%0b c=%0h rd=%0d we=%0b ld=%0b exp all 0", ex_valid, ex_alu_control, ex_rd, ex_rd_we, ex_is_load); else passed++;
    checks++; if ({ex_op1, ex_op2} !== 64'h0)
      $display("FAIL reset_ops got %0h/%0h exp 0/0", ex_op1, ex_op2); else passed++;
    ex_ready = 0; #1;
    checks++; if (id_ready !== 1'b0) $display("FAIL reset_idready_lo got %0b exp 0", id_ready); else passed++;
    ex_ready = 1; #1;
    checks++; if (id_ready !== 1'b1) $display("FAIL reset_idready_hi got %0b exp 1", id_ready); else passed++;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle(); drive_id(19'h1, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7);
    sb.push_back('{19'h1, 32'd5, 32'd7}); #1;
    checks++; if (id_ready !== 1'b1) $display("FAIL b2b_ready1 got %0b exp 1", id_ready); else passed++;
    @(negedge clk); idle(); drive_id(19'h2, 5'd6, 5'd7, 5'd8, 32'd10, 32'd3);
    sb.push_back('{19'h2, 32'd10, 32'd3}); #1;
    e = sb.pop_front(); checks++;
    if ({ex_valid, ex_alu_control, ex_op1, ex_op2} !== {1'b1, e.ctrl, e.op1, e.op2})
      $display("FAIL b2b_add got v=%0b c=%0h op1=%0h op2=%0h exp c=%0h op1=%0h op2=%0h", ex_valid, ex_alu_control, ex_op1, ex_op2, e.ctrl, e.op1, e.op2); else passed++;
    checks++; if (id_ready !== 1'b1) $display("FAIL b2b_ready2 got %0b exp 1", id_ready); else passed++;
    @(negedge clk); idle(); #1;
    e = sb.pop_front(); checks++;
    if ({ex_valid, ex_alu_control, ex_op1, ex_op2} !== {1'b1, e.ctrl, e.op1, e.op2})
      $display("FAIL b2b_sub got v=%0b c=%0h op1=%0h op2=%0h exp c=%0h op1=%0h op2=%0h", ex_valid, ex_alu_control, ex_op1, ex_op2, e.ctrl, e.op1, e.op2); else passed++;
    @(negedge clk); idle(); #1;
    checks++; if ({ex_valid, ex_alu_control} !== '0)
      $display("FAIL b2b_drain got v=%0b c=%0h exp 0/0", ex_valid, ex_alu_control); else passed++;
  endtask

  task automatic test_fwd_exmem();
    @(negedge clk); idle(); drive_id(19'h1, 5'd3, 5'd0, 5'd9, 32'd0, 32'd0);
    sb.push_back('{19'h1, 32'h1234, 32'h0});
    @(negedge clk); idle(); exmem_rd = 5'd3; exmem_rd_we = 1; exmem_res = 32'h1234; #1;
    e = sb.pop_front(); checks++;
    if ({ex_valid, ex_alu_control, ex_op1, ex_op2} !== {1'b1, e.ctrl, e.op1, e.op2})
      $display("FAIL fwd_exmem got c=%0h op1=%0h op2=%0h exp c=%0h op1=%0h op2=%0h", ex_alu_control, ex_op1, ex_op2, e.ctrl, e.op1, e.op2); else passed++;
    memwb_rd = 5'd3; memwb_rd_we = 1; memwb_data = 32'h9999; #1;
    checks++; if (ex_op1 !== 32'h1234) $display("FAIL fwd_priority got %0h exp 1234", ex_op1); else passed++;
    exmem_rd_we = 0; #1;
    checks++; if (ex_op1 !== 32'h9999) $display("FAIL fwd_memwb got %0h exp 9999", ex_op1); else passed++;
  endtask

  task automatic test_load_use();
    @(negedge clk); idle(); drive_id(19'h1, 5'd1, 5'd0, 5'd4, 32'h100, 32'd0);
    id_is_load = 1; id_use_imm = 1; id_imm = 32'd4;
    sb.push_back('{19'h1, 32'h100, 32'd4});
    @(negedge clk); idle(); drive_id(19'h1, 5'd4, 5'd2, 5'd6, 32'd0, 32'd1); #1;
    e = sb.pop_front(); checks++;
    if ({ex_valid, ex_alu_control, ex_op1, ex_op2, ex_is_load} !== {1'b1, e.ctrl, e.op1, e.op2, 1'b1})
      $display("FAIL lu_load got c=%0h op1=%0h op2=%0h ld=%0b exp c=%0h op1=%0h op2=%0h ld=1", ex_alu_control, ex_op1, ex_op2, ex_is_load, e.ctrl, e.op1, e.op2); else passed++;
    checks++; if (id_ready !== 1'b0) $display("FAIL lu_stall got %0b exp 0", id_ready); else passed++;
    @(negedge clk); memwb_rd = 5'd4; memwb_rd_we = 1; memwb_data = 32'hCAFE;
    sb.push_back('{19'h1, 32'hCAFE, 32'd1}); #1;
    checks++; if ({ex_valid, ex_alu_control} !== '0)
      $display("FAIL lu_bubble got v=%0b c=%0h exp 0/0", ex_valid, ex_alu_control); else passed++;
    checks++; if (id_ready !== 1'b1) $display("FAIL lu_release got %0b exp 1", id_ready); else passed++;
    @(negedge clk); idle(); #1;
    e = sb.pop_front(); checks++;
    if ({ex_valid, ex_alu_control, ex_op1, ex_op2} !== {1'b1, e.ctrl, e.op1, e.op2})
      $display("FAIL lu_consumer got v=%0b c=%0h op1=%0h op2=%0h exp c=%0h op1=%0h op2=%0h", ex_valid, ex_alu_control, ex_op1, ex_op2, e.ctrl, e.op1, e.op2); else passed++;
  endtask

  task automatic test_hold_refresh();
    @(negedge clk); idle(); drive_id(19'h4, 5'd0, 5'd9, 5'd10, 32'd0, 32'h11);
    sb.push_back('{19'h4, 32'h0, 32'h55});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); ex_ready = 0;
      if (c == 0) begin memwb_rd = 5'd9; memwb_rd_we = 1; memwb_data = 32'h55; end
      #1;
      checks++; if ({ex_valid, ex_op2} !== {1'b1, 32'h55})
        $display("FAIL hold_op2 cyc%0d got v=%0b op2=%0h exp v=1 op2=55", c, ex_valid, ex_op2); else passed++;
    end
    @(negedge clk); idle(); #1;
    e = sb.pop_front(); checks++;
    if ({ex_valid, ex_alu_control, ex_op1, ex_op2} !== {1'b1, e.ctrl, e.op1, e.op2})
      $display("FAIL hold_release got c=%0h op1=%0h op2=%0h exp c=%0h op1=%0h op2=%0h", ex_alu_control, ex_op1, ex_op2, e.ctrl, e.op1, e.op2); else passed++;
  endtask

  task automatic test_flush_x0();
    @(negedge clk); idle(); drive_id(19'h8, 5'd0, 5'd0, 5'd11, 32'hDEAD, 32'hBEEF);
    sb.push_back('{19'h8, 32'h0, 32'h0});
    @(negedge clk); idle(); ex_ready = 0;
    exmem_rd = 5'd0; exmem_rd_we = 1; exmem_res = 32'hBEEF;
    memwb_rd = 5'd0; memwb_rd_we = 1; memwb_data = 32'h7777; #1;
    e = sb.pop_front(); checks++;
    if ({ex_valid, ex_alu_control, ex_op1, ex_op2} !== {1'b1, e.ctrl, e.op1, e.op2})
      $display("FAIL x0_ops got c=%0h op1=%0h op2=%0h exp c=%0h op1=%0h op2=%0h", ex_alu_control, ex_op1, ex_op2, e.ctrl, e.op1, e.op2); else passed++;
    @(negedge clk); idle(); ex_ready = 0; flush = 1;
    drive_id(19'h10, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2); #1;
    checks++; if (id_ready !== 1'b0) $display("FAIL flush_ready got %0b exp 0", id_ready); else passed++;
    @(negedge clk); idle(); ex_ready = 0; #1;
    checks++; if ({ex_valid, ex_alu_control} !== '0)
      $display("FAIL flush_clear got v=%0b c=%0h exp 0/0", ex_valid, ex_alu_control); else passed++;
    @(negedge clk); idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle(); drive_id(19'h10, 5'd2, 5'd3, 5'd12, 32'hA, 32'hB);
    sb.push_back('{19'h10, 32'hA, 32'hB});
    @(negedge clk); idle(); #1;
    e = sb.pop_front(); checks++;
    if ({ex_valid, ex_alu_control, ex_op1, ex_op2} !== {1'b1, e.ctrl, e.op1, e.op2})
      $display("FAIL arst_pre got v=%0b c=%0h op1=%0h op2=%0h exp c=%0h op1=%0h op2=%0h", ex_valid, ex_alu_control, ex_op1, ex_op2, e.ctrl, e.op1, e.op2); else passed++;
    #2; rst_n = 0; #1;
    checks++; if ({ex_valid, ex_alu_control, ex_op1} !== '0)
      $display("FAIL arst_clear got v=%0b c=%0h op1=%0h exp 0/0/0", ex_valid, ex_alu_control, ex_op1); else passed++;
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fwd_exmem();
    test_load_use();
    test_hold_refresh();
    test_flush_x0();
    test_async_reset();
    checks++; if (sb.size() != 0) $display("FAIL sb_empty got %0d entries exp 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
